// File: rtl/rv32im_fetch.sv
`timescale 1ns/1ps
// rv32im_fetch: instruction fetch stage of the rv32im pipeline.
//
// Owns the program counter and issues single-outstanding word reads to
// instruction memory. Each fetched word is placed, together with its address,
// in a one-entry output buffer that decode consumes over valid/ready.
// Redirects from later stages replace the PC. A DISCARD state swallows the
// stale word of a request that was in flight when the redirect arrived.
// Misaligned redirect targets park the stage in FAULT until an aligned
// redirect or reset.
//
// Handshakes:
//   memory side : fetch_req_o/fetch_addr_o are held stable until fetch_ack_i.
//                 fetch_ack_i is only meaningful while fetch_req_o is high.
//                 fetch_data_i is valid in the ack cycle.
//   decode side : a transfer happens in every cycle where
//                 instr_valid_o & instr_ready_i. instr_o/pc_o are stable
//                 while instr_valid_o is high and instr_ready_i is low.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   fetch_addr_o            word-aligned read address
//   fetch_req_o             read request (combinational)
//   fetch_ack_i             read complete, fetch_data_i valid
//   fetch_data_i            instruction word from memory
//   redirect_i              one-cycle pulse: restart at redirect_addr_i
//   redirect_addr_i         new PC
//   instr_o, pc_o           buffered instruction and its address
//   instr_valid_o           output buffer holds a valid instruction
//   instr_ready_i           decode accepts the buffered instruction
//   fault_o                 sticky misaligned-redirect fault
//   state_o                 FSM state for debug (0 REQ, 1 DISCARD, 2 FAULT)
module rv32im_fetch #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic [XLEN-1:0] fetch_addr_o,
    output logic            fetch_req_o,
    input  logic            fetch_ack_i,
    input  logic [31:0]     fetch_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic            fault_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_DISCARD = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q;        // address presented to memory
    logic            pend_fault_q;  // last redirect target was misaligned
    logic            ack_v;
    logic            load;
    logic            misaligned;

    assign ack_v      = fetch_req_o & fetch_ack_i;
    assign misaligned = |redirect_addr_i[1:0];
    // Only a non-redirected ack in REQ delivers a word to decode.
    assign load       = (state_q == ST_REQ) & ack_v & ~redirect_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            // A request still waiting for its ack must be drained first.
            if (fetch_req_o & ~fetch_ack_i) begin
                state_d = ST_DISCARD;
            end else if (misaligned) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_REQ;
            end
        end else if ((state_q == ST_DISCARD) && ack_v) begin
            state_d = pend_fault_q ? ST_FAULT : ST_REQ;
        end
    end

    // ---------------- output logic ----------------
    // In REQ no explicit "request held" flag is needed: a request that went
    // out without an ack leaves the buffer empty next cycle (it was either
    // empty already or drained in that same cycle), so ~instr_valid_o keeps
    // the request asserted until the ack arrives.
    always_comb begin
        fetch_req_o = 1'b0;
        if (!reset_i) begin
            case (state_q)
                ST_REQ:     fetch_req_o = ~instr_valid_o | instr_ready_i;
                ST_DISCARD: fetch_req_o = 1'b1;
                default:    fetch_req_o = 1'b0;
            endcase
        end
    end

    assign state_o      = state_q;
    assign fetch_addr_o = {addr_q[XLEN-1:2], 2'b00};

    // ---------------- datapath ----------------
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_addr_i;
        end else if (load) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q          <= RESET_VECTOR;
            addr_q        <= RESET_VECTOR;
            pend_fault_q  <= 1'b0;
            instr_o       <= '0;
            pc_o          <= '0;
            instr_valid_o <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            pc_q <= pc_d;
            // The in-flight address stays on the bus while a stale word is
            // drained; otherwise the bus follows the PC.
            if (state_d != ST_DISCARD) begin
                addr_q <= pc_d;
            end
            if (redirect_i) begin
                pend_fault_q <= misaligned;
            end
            fault_o <= (state_d == ST_FAULT);
            // A drain in a redirect cycle is still a valid transfer; the
            // buffer is simply emptied either way.
            if (redirect_i) begin
                instr_valid_o <= 1'b0;
            end else if (load) begin
                instr_valid_o <= 1'b1;
                instr_o       <= fetch_data_i;
                pc_o          <= pc_q;
            end else if (instr_ready_i) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32im_fetch.sv
`timescale 1ns/1ps
// Testbench for rv32im_fetch: a per-cycle table of inputs and expected
// outputs, followed by hand-written streaming and fault sequences.
module tb_rv32im_fetch;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] fetch_addr_o;
    logic        fetch_req_o;
    logic        fetch_ack_i = 1'b0;
    logic [31:0] fetch_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic        fault_o;
    logic [1:0]  state_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];

    rv32im_fetch #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .fetch_addr_o    (fetch_addr_o),
        .fetch_req_o     (fetch_req_o),
        .fetch_ack_i     (fetch_ack_i),
        .fetch_data_i    (fetch_data_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .fault_o         (fault_o),
        .state_o         (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // Memory contents: a recognisable word per address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] data;
        logic        rdr;
        logic [31:0] raddr;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_flt;
        logic        chk;    // registered outputs are defined in this row
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, input logic ack, input logic [31:0] ack_addr,
                     input logic rdr, input logic [31:0] raddr, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                     input logic [31:0] e_pc, input logic e_flt, input logic chk);
        vec_t r;
        r.rst = rst; r.ack = ack; r.data = ack ? w(ack_addr) : 32'hDEAD_BEEF;
        r.rdr = rdr; r.raddr = raddr; r.rdy = rdy;
        r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld;
        r.e_pc = e_pc; r.e_flt = e_flt; r.chk = chk;
        vecs.push_back(r);
    endtask

    // Inputs are applied at the falling edge; outputs sampled 1ns later.
    task automatic apply(input vec_t r, input int idx);
        @(negedge clk_i);
        reset_i = r.rst; fetch_ack_i = r.ack; fetch_data_i = r.data;
        redirect_i = r.rdr; redirect_addr_i = r.raddr; instr_ready_i = r.rdy;
        #1;
        chk1($sformatf("v%0d_req", idx), fetch_req_o, r.e_req);
        if (r.e_req) chk32($sformatf("v%0d_addr", idx), fetch_addr_o, r.e_addr);
        if (r.chk) begin
            chk1($sformatf("v%0d_vld", idx), instr_valid_o, r.e_vld);
            chk1($sformatf("v%0d_flt", idx), fault_o, r.e_flt);
            if (r.e_vld) begin
                chk32($sformatf("v%0d_pc", idx), pc_o, r.e_pc);
                chk32($sformatf("v%0d_instr", idx), instr_o, w(r.e_pc));
            end
        end
    endtask

    initial begin
        int n_valid;
        logic [31:0] exp_addr;
        logic [31:0] e;

        //  rst ack addr           rdr raddr          rdy req e_addr         vld e_pc           flt chk
        v(1, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         0,  0);
        v(1, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         0,  1);
        // zero-wait streaming
        v(0, 1, 32'h0,         0, 32'h0,         1,  1, 32'h0,         0, 32'h0,         0,  1);
        v(0, 1, 32'h4,         0, 32'h0,         1,  1, 32'h4,         1, 32'h0,         0,  1);
        v(0, 1, 32'h8,         0, 32'h0,         1,  1, 32'h8,         1, 32'h4,         0,  1);
        // backpressure: 5 cycles, buffer holds 0x8, no request
        for (int i = 0; i < 5; i++)
            v(0, 0, 32'h0,     0, 32'h0,         0,  0, 32'hC,         1, 32'h8,         0,  1);
        // release: drain and load in the same cycle
        v(0, 1, 32'hC,         0, 32'h0,         1,  1, 32'hC,         1, 32'h8,         0,  1);
        v(0, 1, 32'h10,        0, 32'h0,         1,  1, 32'h10,        1, 32'hC,         0,  1);
        // request outstanding across ready low
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h14,        1, 32'h10,        0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h14,        0, 32'h0,         0,  1);
        v(0, 1, 32'h14,        0, 32'h0,         0,  1, 32'h14,        0, 32'h0,         0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         0,  0, 32'h18,        1, 32'h14,        0,  1);
        v(0, 1, 32'h18,        0, 32'h0,         1,  1, 32'h18,        1, 32'h14,        0,  1);
        // redirect to 0x40 while 0x1C outstanding, stale ack next cycle
        v(0, 0, 32'h0,         1, 32'h40,        1,  1, 32'h1C,        1, 32'h18,        0,  1);
        v(0, 1, 32'h1C,        0, 32'h0,         1,  1, 32'h1C,        0, 32'h0,         0,  1);
        // 0x40 waits; redirect to 0x100 meanwhile; ack 3 cycles later
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h40,        0, 32'h0,         0,  1);
        v(0, 0, 32'h0,         1, 32'h100,       1,  1, 32'h40,        0, 32'h0,         0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h40,        0, 32'h0,         0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h40,        0, 32'h0,         0,  1);
        v(0, 1, 32'h40,        0, 32'h0,         1,  1, 32'h40,        0, 32'h0,         0,  1);
        v(0, 1, 32'h100,       0, 32'h0,         1,  1, 32'h100,       0, 32'h0,         0,  1);
        v(0, 1, 32'h104,       0, 32'h0,         1,  1, 32'h104,       1, 32'h100,       0,  1);
        // redirect to 0x200 in the same cycle as an ack
        v(0, 1, 32'h108,       1, 32'h200,       1,  1, 32'h108,       1, 32'h104,       0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h200,       0, 32'h0,         0,  1);
        v(0, 1, 32'h200,       0, 32'h0,         1,  1, 32'h200,       0, 32'h0,         0,  1);
        // misaligned redirect 0x102 while 0x204 outstanding
        v(0, 0, 32'h0,         1, 32'h102,       1,  1, 32'h204,       1, 32'h200,       0,  1);
        v(0, 1, 32'h204,       0, 32'h0,         1,  1, 32'h204,       0, 32'h0,         0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         1,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         1,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         1,  1);
        // aligned redirect clears the fault
        v(0, 0, 32'h0,         1, 32'h300,       1,  0, 32'h0,         0, 32'h0,         1,  1);
        v(0, 1, 32'h300,       0, 32'h0,         1,  1, 32'h300,       0, 32'h0,         0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h304,       1, 32'h300,       0,  1);
        // misaligned redirect with the ack in the same cycle: straight to FAULT
        v(0, 1, 32'h304,       1, 32'h6,         1,  1, 32'h304,       0, 32'h0,         0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         1,  1);
        // PC wrap
        v(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1,  0, 32'h0,         0, 32'h0,         1,  1);
        v(0, 1, 32'hFFFF_FFFC, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, 32'h0,         0,  1);
        v(0, 1, 32'h0,         0, 32'h0,         1,  1, 32'h0,         1, 32'hFFFF_FFFC, 0,  1);
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h4,         1, 32'h0,         0,  1);
        // reset mid-request drops it
        v(1, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         0,  0);
        v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h0,         0, 32'h0,         0,  1);

        foreach (vecs[i]) apply(vecs[i], i);

        // ---------------- streaming with reactive zero-wait memory ----------------
        @(negedge clk_i);
        reset_i = 1'b1; fetch_ack_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk1("rst_req", fetch_req_o, 1'b0);
        chk1("rst_vld", instr_valid_o, 1'b0);
        chk1("rst_flt", fault_o, 1'b0);
        chk32("rst_pc", pc_o, 32'h0);
        chk32("rst_instr", instr_o, 32'h0);

        n_valid  = 0;
        exp_addr = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            reset_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b1;
            #1;
            fetch_ack_i  = fetch_req_o;
            fetch_data_i = w(fetch_addr_o);
            if (instr_valid_o) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk1("stream_unexpected_valid", instr_valid_o, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk32("stream_pc", pc_o, e);
                    chk32("stream_instr", instr_o, w(e));
                end
            end
            chk1("stream_req", fetch_req_o, 1'b1);
            chk32("stream_addr", fetch_addr_o, exp_addr);
            exp_q.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
        end
        chk32("stream_count", 32'(n_valid), 32'd19);

        // ---------------- fault holds the request low ----------------
        @(negedge clk_i);
        redirect_i = 1'b1; redirect_addr_i = 32'h102;
        #1;
        fetch_ack_i = fetch_req_o;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            redirect_i = 1'b0; fetch_ack_i = 1'b0;
            #1;
            chk1("fault_req", fetch_req_o, 1'b0);
            chk1("fault_flag", fault_o, 1'b1);
            chk1("fault_vld", instr_valid_o, 1'b0);
        end
        @(negedge clk_i);
        redirect_i = 1'b1; redirect_addr_i = 32'h300;
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        chk1("clear_flt", fault_o, 1'b0);
        chk1("clear_req", fetch_req_o, 1'b1);
        chk32("clear_addr", fetch_addr_o, 32'h300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
